pucch_re_mapper: RTL
====================

// Module: pucch_re_mapper
// PURPOSE
//  Downstream of the PUCCH F0/F1 sequence generator. Absorbs its 12-sample-per-symbol bursts
//  (sfix16_En15 I/Q, no backpressure) in a 2-bank ping-pong buffer. Replays them to the
//  resource-grid writer with valid/ready handshake, tagged with OFDM symbol and absolute
//  subcarrier index.
// PARAMETERS
//  DW          16   I/Q sample width (sfix16_En15)
//  N_PRB_MAX   275  highest PRB index + 1 accepted on i_prb/i_prb2
//  SC_W        12   width of o_sc (covers N_PRB_MAX*12-1 = 3299)
// PORTS
//  clk          in   1     clock; single clock domain
//  rst_n        in   1     synchronous reset, active-low
//  i_start      in   1     1-cycle pulse: latch config, clear flags, enter RUN
//  i_format     in   3     0 = F0, 1 = F1; other values -> DONE immediately, o_err=1
//  i_symStart   in   4     first PUCCH symbol (0-13)
//  i_nPUCCHSym  in   4     allocated symbols (F0: 1-2, F1: 4-14)
//  i_prb        in   9     PRB of first hop (0..N_PRB_MAX-1)
//  i_prb2       in   9     PRB of second hop (used only with PUCCH_INTRASLOT_HOP_EN)
//  i_re,i_im    in   DW    upstream sample
//  i_valid      in   1     upstream sample strobe (bursts of exactly 12)
//  i_done       in   1     upstream level "all bursts produced"
//  o_re,o_im    out  DW    mapped sample
//  o_sym        out  4     OFDM symbol index of o_re/o_im
//  o_sc         out  SC_W  subcarrier index = prb*12 + k, k = 0..11
//  o_valid      out  1     output strobe; held with data stable until i_ready
//  i_ready      in   1     grid writer accepts sample when o_valid & i_ready
//  o_done       out  1     level: all bursts drained; held until next i_start
//  o_err        out  1     sticky: overflow, partial burst or bad format; cleared by i_start
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state IDLE; both banks empty; all outputs 0.
//  - FSM: IDLE -i_start-> RUN. RUN -(i_done & write idx==0 & both banks empty)-> DONE.
//    DONE -i_start-> RUN. i_start in any state restarts: banks flushed, counters zeroed.
//  - Write side: wr_idx 0..11 into wr_bank. The 12th sample marks bank full, toggles
//    wr_bank, increments burst count b.
//  - i_valid while target bank full: sample dropped, o_err=1, burst still counted.
//  - Read side: if rd_bank full, o_valid=1 from cycle after the edge capturing 12th sample
//    (1-cycle latency). rd_idx advances on o_valid&i_ready. After k=11 accepted, bank freed
//    and rd_bank toggles. Same-cycle write-complete and read-free on different banks both
//    take effect.
//  - With i_ready=1 continuously: 12 outputs in 12 consecutive cycles per burst, back-to-back.
//  - Symbol tag: F0 o_sym = symStart + b; F1 o_sym = symStart + 2*b + 1 (data symbols only).
//    4-bit arithmetic, no wrap check (caller guarantees symStart+nPUCCHSym <= 14).
//  - o_sc = prb_sel*12 + k, computed in SC_W bits. prb_sel = latched i_prb unless hop enabled.
//  - i_done while wr_idx != 0: partial burst discarded, o_err=1.
//  - o_done asserts the cycle after the last buffered sample is accepted.
//  - Zero bursts (upstream done at once, e.g. negative-SR only): o_done 1 cycle after i_done.
//  - Reset mid-burst: buffer contents and handshake dropped, no further o_valid.
// CONFIGURATION
//  PUCCH_INTRASLOT_HOP_EN defined: nB = (F0 ? nPUCCHSym : nPUCCHSym>>1).
//    Bursts b <  nB>>1 use i_prb; bursts b >= nB>>1 use i_prb2.
//    For nB=1 all bursts use i_prb2 since nB>>1 = 0. i_prb2 is latched on i_start.
//  Not defined: i_prb2 ignored, every burst uses i_prb.
// TESTING
//  1 F0, symStart=12, nPUCCHSym=2, prb=10, ready=1, 2 bursts:
//    24 outputs; sym 12 then 13; sc 120..131 each; o_done 1 cycle after last; o_err=0.
//  2 F1, symStart=0, nPUCCHSym=14, prb=0: 7 bursts tagged sym 1,3,..,13; sc 0..11.
//  3 i_ready=0 for 40 cycles while 3 bursts arrive:
//    bursts 1-2 buffered, 3rd dropped with o_err=1; first 24 samples emerge intact in order.
//  4 Random i_ready (50%): output stream equals input stream per burst.
//    o_re/o_im/o_sc stable while o_valid & !i_ready.
//  5 i_done after 7 samples of a burst: those 7 never output, o_err=1, o_done asserts.
//  6 HOP_EN, F1, nPUCCHSym=14, prb=5, prb2=100:
//    bursts 0-2 sc 60..71; bursts 3-6 sc 1200..1211.
//    Without macro, all bursts sc 60..71.

Source files
------------

// File: rtl/pucch_re_mapper.sv
// -----------------------------------------------------------------------------
// pucch_re_mapper
//
// Purpose:
//    Sits behind the PUCCH F0/F1 sequence generator. Each OFDM symbol arrives
//    as a burst of exactly 12 I/Q samples with no backpressure. Bursts are
//    absorbed into a two-bank ping-pong buffer and replayed to the
//    resource-grid writer over a valid/ready handshake. Each replayed sample
//    is tagged with its OFDM symbol index and its absolute subcarrier index.
//
// Optional feature (compile-time macro):
//    PUCCH_INTRASLOT_HOP_EN  - when defined, later bursts are mapped onto the
//                              second-hop PRB (i_prb2); otherwise i_prb2 is
//                              ignored and every burst uses i_prb.
//
// Ports:
//    clk          clock, single domain
//    rst_n        synchronous reset, active low
//    i_start      1-cycle pulse: latch config, flush buffers, clear flags
//    i_format     0 = F0, 1 = F1, anything else finishes at once with o_err
//    i_symStart   first PUCCH symbol
//    i_nPUCCHSym  number of allocated PUCCH symbols
//    i_prb        PRB of the first hop
//    i_prb2       PRB of the second hop (hopping builds only)
//    i_re, i_im   upstream sample
//    i_valid      upstream sample strobe (bursts of 12)
//    i_done       upstream level: all bursts produced
//    o_re, o_im   mapped sample (zero while o_valid is low)
//    o_sym        OFDM symbol of the current output sample
//    o_sc         absolute subcarrier = prb*12 + k
//    o_valid      output strobe, held with stable data until i_ready
//    i_ready      grid writer accepts when o_valid & i_ready
//    o_done       level: everything drained, held until next i_start
//    o_err        sticky: overflow, partial burst or bad format
// -----------------------------------------------------------------------------
module pucch_re_mapper #(
   parameter int DW        = 16,
   parameter int N_PRB_MAX = 275,
   parameter int SC_W      = 12
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_start,
   input  logic [2:0]                   i_format,
   input  logic [3:0]                   i_symStart,
   input  logic [3:0]                   i_nPUCCHSym,
   input  logic [$clog2(N_PRB_MAX)-1:0] i_prb,
   input  logic [$clog2(N_PRB_MAX)-1:0] i_prb2,
   input  logic [DW-1:0]                i_re,
   input  logic [DW-1:0]                i_im,
   input  logic                         i_valid,
   input  logic                         i_done,
   output logic [DW-1:0]                o_re,
   output logic [DW-1:0]                o_im,
   output logic [3:0]                   o_sym,
   output logic [SC_W-1:0]             o_sc,
   output logic                         o_valid,
   input  logic                         i_ready,
   output logic                         o_done,
   output logic                         o_err
);

   localparam int         PRB_W    = $clog2(N_PRB_MAX);
   localparam int         NSC      = 12;
   localparam logic [3:0] LAST_IDX = 4'd11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_reg, state_next;

   // Configuration latched on i_start
   logic             fmt_f1_reg;
   logic [3:0]       sym_start_reg;
   logic [PRB_W-1:0] prb_reg;
`ifdef PUCCH_INTRASLOT_HOP_EN
   logic [PRB_W-1:0] prb2_reg;
   logic [3:0]       n_sym_reg;
`endif

   // Ping-pong storage: two banks of one burst each
   logic [DW-1:0] mem_re_reg [2][NSC];
   logic [DW-1:0] mem_im_reg [2][NSC];
   logic [1:0]    full_reg, full_next;
   logic [3:0]    burst_tag_reg [2];   // burst count b of the burst held in each bank

   // Write side
   logic       wr_bank_reg;
   logic [3:0] wr_idx_reg, wr_idx_next;
   logic       drop_reg;               // current burst is being discarded
   logic [3:0] b_reg;                  // bursts seen so far, dropped ones included

   // Read side
   logic       rd_bank_reg;
   logic [3:0] rd_idx_reg;

   logic       err_reg;

   logic             fmt_ok;
   logic             run;
   logic             abort;
   logic             wr_fire, wr_first, wr_last, wr_drop, wr_store, wr_complete;
   logic             rd_avail, rd_fire, rd_last, rd_free;
   logic             done_cond;
   logic [3:0]       rd_b;
   logic [PRB_W-1:0] prb_sel;
   logic [3:0]       sym_calc;
   logic [SC_W-1:0]  sc_calc;

   assign fmt_ok = (i_format == 3'd0) || (i_format == 3'd1);
   assign run    = (state_reg == RUN);

   // ---------------------------------------------------------------- write side
   // i_done arriving mid-burst means the burst will never complete: throw it away.
   assign abort    = run & i_done & (wr_idx_reg != 4'd0);
   assign wr_fire  = run & i_valid & ~abort;
   assign wr_first = (wr_idx_reg == 4'd0);
   assign wr_last  = (wr_idx_reg == LAST_IDX);
   // Whether a burst is kept is decided on its first sample, so a bank that
   // frees up halfway through a dropped burst never receives a torn burst.
   assign wr_drop     = wr_first ? full_reg[wr_bank_reg] : drop_reg;
   assign wr_store    = wr_fire & ~wr_drop;
   assign wr_complete = wr_store & wr_last;

   always_comb begin
      wr_idx_next = wr_idx_reg;
      if (abort) begin
         wr_idx_next = 4'd0;
      end else if (wr_fire) begin
         wr_idx_next = wr_last ? 4'd0 : wr_idx_reg + 4'd1;
      end
   end

   // ----------------------------------------------------------------- read side
   assign rd_avail = full_reg[rd_bank_reg];
   assign rd_last  = (rd_idx_reg == LAST_IDX);
   assign rd_fire  = rd_avail & i_ready;
   assign rd_free  = rd_fire & rd_last;
   assign rd_b     = burst_tag_reg[rd_bank_reg];

   // A bank can only be completed by a write while it is empty and only freed
   // by a read while it is full, so both events on the same edge never collide.
   for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      assign full_next[gi] = (full_reg[gi] & ~(rd_free & (rd_bank_reg == 1'(gi))))
                           | (wr_complete & (wr_bank_reg == 1'(gi)));
   end

   // Looking at next-state values lets DONE arrive on the same edge that
   // accepts the final sample.
   assign done_cond = i_done & (wr_idx_next == 4'd0) & (full_next == 2'b00);

   // ------------------------------------------------------------ tag generation
`ifdef PUCCH_INTRASLOT_HOP_EN
   logic [3:0] n_b;
   // F1 carries data only on every other symbol, so it has half as many bursts.
   assign n_b     = fmt_f1_reg ? (n_sym_reg >> 1) : n_sym_reg;
   assign prb_sel = (rd_b < (n_b >> 1)) ? prb_reg : prb2_reg;
`else
   logic unused_cfg;
   assign unused_cfg = ^{i_prb2, i_nPUCCHSym};
   assign prb_sel    = prb_reg;
`endif

   // F1 data symbols sit at odd offsets; DM-RS occupies the even ones.
   assign sym_calc = fmt_f1_reg ? (sym_start_reg + {rd_b[2:0], 1'b0} + 4'd1)
                                : (sym_start_reg + rd_b);
   assign sc_calc  = SC_W'(prb_sel) * SC_W'(NSC) + SC_W'(rd_idx_reg);

   assign o_valid = rd_avail;
   assign o_re    = rd_avail ? mem_re_reg[rd_bank_reg][rd_idx_reg] : '0;
   assign o_im    = rd_avail ? mem_im_reg[rd_bank_reg][rd_idx_reg] : '0;
   assign o_sym   = rd_avail ? sym_calc : 4'd0;
   assign o_sc    = rd_avail ? sc_calc  : '0;
   assign o_err   = err_reg;

   // ------------------------------------------------------------------------ FSM
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      o_done     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (i_start) begin
               state_next = fmt_ok ? RUN : DONE;
            end
         end
         RUN: begin
            if (i_start) begin
               state_next = fmt_ok ? RUN : DONE;
            end else if (done_cond) begin
               state_next = DONE;
            end
         end
         DONE: begin
            o_done = 1'b1;
            if (i_start) begin
               state_next = fmt_ok ? RUN : DONE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------- control regs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fmt_f1_reg       <= 1'b0;
         sym_start_reg    <= 4'd0;
         prb_reg          <= '0;
`ifdef PUCCH_INTRASLOT_HOP_EN
         prb2_reg         <= '0;
         n_sym_reg        <= 4'd0;
`endif
         full_reg         <= 2'b00;
         burst_tag_reg[0] <= 4'd0;
         burst_tag_reg[1] <= 4'd0;
         wr_bank_reg      <= 1'b0;
         wr_idx_reg       <= 4'd0;
         drop_reg         <= 1'b0;
         b_reg            <= 4'd0;
         rd_bank_reg      <= 1'b0;
         rd_idx_reg       <= 4'd0;
         err_reg          <= 1'b0;
      end else if (i_start) begin
         fmt_f1_reg    <= (i_format == 3'd1);
         sym_start_reg <= i_symStart;
         prb_reg       <= i_prb;
`ifdef PUCCH_INTRASLOT_HOP_EN
         prb2_reg      <= i_prb2;
         n_sym_reg     <= i_nPUCCHSym;
`endif
         full_reg      <= 2'b00;
         wr_bank_reg   <= 1'b0;
         wr_idx_reg    <= 4'd0;
         drop_reg      <= 1'b0;
         b_reg         <= 4'd0;
         rd_bank_reg   <= 1'b0;
         rd_idx_reg    <= 4'd0;
         err_reg       <= ~fmt_ok;
      end else begin
         full_reg   <= full_next;
         wr_idx_reg <= wr_idx_next;

         if (abort) begin
            drop_reg <= 1'b0;
         end else if (wr_fire) begin
            drop_reg <= wr_last ? 1'b0 : wr_drop;
         end

         // Dropped bursts still advance b so later symbols keep their tags.
         if (wr_fire && wr_last) begin
            b_reg <= b_reg + 4'd1;
         end

         if (wr_complete) begin
            wr_bank_reg                <= ~wr_bank_reg;
            burst_tag_reg[wr_bank_reg] <= b_reg;
         end

         if (rd_fire) begin
            rd_idx_reg <= rd_last ? 4'd0 : rd_idx_reg + 4'd1;
         end
         if (rd_free) begin
            rd_bank_reg <= ~rd_bank_reg;
         end

         if (abort || (wr_fire && wr_first && full_reg[wr_bank_reg])) begin
            err_reg <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------- sample RAM
   always_ff @(posedge clk) begin
      if (wr_store) begin
         mem_re_reg[wr_bank_reg][wr_idx_reg] <= i_re;
         mem_im_reg[wr_bank_reg][wr_idx_reg] <= i_im;
      end
   end

endmodule
